// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data memory responder with wait states, sub-word access and misalignment detection
module data_mem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ReadEnable,
    input  logic                  WriteEnable,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] WRData,
    output logic [DATA_WIDTH-1:0] RDData,
    output logic                  RDValid,
    output logic                  Done,
    output logic                  Busy,
    output logic                  MisalignErr
);
    localparam int         IDX_W     = ADDR_WIDTH - 2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  write_q;
    logic [DATA_WIDTH-1:0] rddata_q;
    logic                  rdvalid_q;
    logic                  done_q;
    logic                  err_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0]      idx;
    logic [1:0]            lane;
    logic                  req_err;
    logic [DATA_WIDTH-1:0] word;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_data;
    logic [3:0]            be;
    logic [DATA_WIDTH-1:0] wlane;
    logic                  mem_we;

    assign idx  = addr_q[ADDR_WIDTH-1:2];
    assign lane = addr_q[1:0];
    assign word = mem[idx];

    always_comb begin
        req_err = 1'b0;
        case (funct3_q)
            3'b000, 3'b100: req_err = 1'b0;
            3'b001, 3'b101: req_err = lane[0];
            3'b010:         req_err = |lane;
            default:        req_err = 1'b1;
        endcase
    end

    always_comb begin
        byte_sel = word[7:0];
        case (lane)
            2'd0: byte_sel = word[7:0];
            2'd1: byte_sel = word[15:8];
            2'd2: byte_sel = word[23:16];
            2'd3: byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_data = {24'h0, byte_sel};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = word;
        endcase
        if (req_err) begin
            load_data = '0;
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        case (funct3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wlane = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wlane = {2{wdata_q[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = wdata_q;
            end
        endcase
    end

    // Gated by rst so an access edge that coincides with reset never commits.
    assign mem_we = (state_q == S_ACCESS) && write_q && !req_err && rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[idx][8*k +: 8] <= wlane[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            funct3_q  <= 3'd0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            rddata_q  <= '0;
            rdvalid_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rdvalid_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ReadEnable || WriteEnable) begin
                        addr_q   <= Address;
                        funct3_q <= Funct3;
                        wdata_q  <= WRData;
                        write_q  <= WriteEnable;
                        cnt_q    <= WAIT_INIT;
                        state_q  <= (WAIT_INIT != 4'd0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    done_q <= 1'b1;
                    err_q  <= req_err;
                    if (!write_q) begin
                        rddata_q  <= load_data;
                        rdvalid_q <= 1'b1;
                    end
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign RDData      = rddata_q;
    assign RDValid     = rdvalid_q;
    assign Done        = done_q;
    assign MisalignErr = err_q;
    assign Busy        = (state_q != S_IDLE);

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core's data memory interface: accepts load/store requests (ReadEnable, WriteEnable, Address, WRData, Funct3) and returns RDData.
- Byte-addressed, little-endian word store with configurable wait states, byte/half/word access, sign/zero extension and misalignment detection.
- Sits beside DataPath in the top level and serves as the data memory for simulation and FPGA builds.

Parameters:
- DATA_WIDTH, 32: word width; only 32 is supported.
- ADDR_WIDTH, 9: byte address width.
- DEPTH_WORDS, 128: number of storage words, equal to 2^(ADDR_WIDTH-2).
- WAIT_CYCLES, 1: extra cycles inserted between acceptance and access, range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ReadEnable  in  1  load request.
- WriteEnable  in  1  store request.
- Address  in  ADDR_WIDTH  byte address.
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- WRData  in  DATA_WIDTH  store data, least-significant bytes used for B/H.
- RDData  out  DATA_WIDTH  load result, registered.
- RDValid  out  1  one-cycle pulse when RDData updates from a load.
- Done  out  1  one-cycle pulse on completion of any request.
- Busy  out  1  high while a request is in flight.
- MisalignErr  out  1  one-cycle pulse with Done when a request was misaligned or had an illegal Funct3.

Behaviour:
- Reset (rst=0, asynchronous): state returns to IDLE and the counter clears. RDData=0, RDValid=0, Done=0, Busy=0, MisalignErr=0. Storage is not cleared. Reset in the middle of an operation drops the pending request, and a pending store is not committed.
- FSM: IDLE -> WAIT -> ACCESS -> IDLE.
  - IDLE: at an edge with ReadEnable|WriteEnable=1, capture Address, Funct3, WRData and the operation (write has priority if both are high, and the read is discarded).
    - Load the counter with WAIT_CYCLES.
    - Go to WAIT if WAIT_CYCLES>0, else go to ACCESS.
  - WAIT: decrement the counter each edge; go to ACCESS at the edge where the counter equals 1.
  - ACCESS: perform the access at this edge, then go to IDLE.
- Busy=1 in WAIT and ACCESS. Requests presented while Busy=1 are ignored and not queued.
- Latency: accept at edge E0, access at edge E(WAIT_CYCLES+1). RDValid, Done and MisalignErr are high during the cycle after that edge, which is the first IDLE cycle. A new request may be accepted at the edge that ends that cycle.
- Word index = Address[ADDR_WIDTH-1:2]. Byte lane = Address[1:0]. Lane k holds bits [8k+7:8k].
- Stores:
  - B: write lane Address[1:0] with WRData[7:0].
  - H: write lanes {A[1],0} and {A[1],1} with WRData[15:0].
  - W: write all lanes.
  - Untouched lanes are preserved.
- Loads: extract the byte or half at the lane offset.
  - B and H sign-extend to 32 bits; BU and HU zero-extend; W returns the full word.
- Error cases:
  - Misalignment: H/HU with A[0]=1, or W with A[1:0]!=0.
  - Illegal Funct3: 011, 110, 111.
  - On either, no storage change; loads return RDData=0 with RDValid=1; MisalignErr=1 together with Done.
- Between loads, RDData holds the last value. Stores do not alter RDData.

Test Plan:
- Reset then SW 0xDEADBEEF @0x004 -> Done pulse. LW @0x004 -> RDData=0xDEADBEEF. With WAIT_CYCLES=1, RDValid is high in the 3rd cycle after the accept edge (Busy high for 2 cycles).
- SW 0x11223344 @0x010, SB 0xAA @0x011, SH 0x8001 @0x012 -> LW @0x010 returns 0x8001AA44. LB @0x011 returns 0xFFFFFFAA. LBU @0x011 returns 0x000000AA. LH @0x012 returns 0xFFFF8001. LHU @0x012 returns 0x00008001.
- SW @0x006 (misaligned), then LW @0x004 -> first request gives MisalignErr=1 with Done and no store. LW @0x004 still returns 0xDEADBEEF. LH @0x005 returns RDData=0, RDValid=1, MisalignErr=1.
- ReadEnable held high during Busy with a different Address -> only the first request is served, exactly one RDValid pulse. ReadEnable=WriteEnable=1 in IDLE -> store performed, no RDValid.
- SW 0x12345678 @0x1FC, LW @0x1FC -> 0x12345678, last word, no wrap corruption of word 0. Repeat with WAIT_CYCLES=0 -> RDValid in the 2nd cycle after accept.
- Reset pulse during WAIT of SW 0xCAFEF00D @0x020, then LW @0x020 -> old contents returned. After reset, all outputs were 0 and Busy=0 immediately, independent of clk.
